aes_dec_ctrl: RTL and testbench

AES_DEC_CTRL -- requirements
Module: aes_dec_ctrl

---
 rtl/aes_dec_pkg.sv | 58 +++++
 rtl/aes_round_ctr.sv | 29 ++
 rtl/aes_dec_ctrl.sv | 137 +++++++++++++
 tb/tb_aes_dec_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES decryption controller: state encoding,
// round count, key-index type and the per-state output decode.
package aes_dec_pkg;

  localparam int unsigned NR     = 10;
  localparam int unsigned KIDX_W = 4;

  typedef logic [KIDX_W-1:0] kidx_t;

  localparam kidx_t KIDX_LAST        = kidx_t'(NR);
  localparam kidx_t KIDX_FIRST_ROUND = kidx_t'(NR - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_KEXP     = 3'd2,
    S_INIT_ADD = 3'd3,
    S_ROUND    = 3'd4,
    S_FINAL    = 3'd5,
    S_DONE     = 3'd6
  } dec_state_t;

  typedef struct packed {
    logic ready;
    logic busy;
    logic ct_load;
    logic key_we;
    logic state_en;
    logic sel_init;
    logic sel_last;
    logic out_valid;
  } ctrl_t;

  // Single-bit strobes asserted while the FSM sits in state s; key_idx is handled separately.
  function automatic ctrl_t ctrl_for(input dec_state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_IDLE:     c.ready = 1'b1;
      S_LOAD:     c.ct_load = 1'b1;
      S_KEXP:     c.key_we = 1'b1;
      S_INIT_ADD: begin
        c.state_en = 1'b1;
        c.sel_init = 1'b1;
      end
      S_ROUND:    c.state_en = 1'b1;
      S_FINAL:    begin
        c.state_en = 1'b1;
        c.sel_last = 1'b1;
      end
      S_DONE:     c.out_valid = 1'b1;
      default:    c.ready = 1'b1;
    endcase
    c.busy = ~c.ready;
    return c;
  endfunction

endpackage

// File: rtl/aes_round_ctr.sv
// Round down-counter: parallel load, saturating decrement, zero flag.
module aes_round_ctr
  import aes_dec_pkg::*;
(
  input  logic  clk,
  input  logic  i_reset,
  input  logic  i_load,
  input  kidx_t i_load_val,
  input  logic  i_dec,
  output kidx_t o_cnt,
  output logic  o_zero
);

  kidx_t r_cnt;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - kidx_t'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/aes_dec_ctrl.sv
// AES-128 decryption sequencer: load, optional key expansion, 11 AddRoundKey
// passes (10..0) and a valid/ready handoff of the plaintext. Control only.
module aes_dec_ctrl
  import aes_dec_pkg::*;
#(
  parameter int unsigned KEY_REUSE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              key_same,
  output logic              ready,
  output logic              busy,
  output logic              ct_load,
  output logic              key_we,
  output logic [KIDX_W-1:0] key_idx,
  output logic              state_en,
  output logic              sel_init,
  output logic              sel_last,
  output logic              out_valid,
  input  logic              out_ready
);

  dec_state_t r_state;
  ctrl_t      r_ctrl;
  kidx_t      r_key_idx;
  logic       r_key_valid;
  logic       r_key_same;

  logic       w_reuse;
  logic       w_ctr_load;
  logic       w_ctr_dec;
  logic       w_ctr_zero;
  kidx_t      w_cnt;

  assign w_reuse    = (KEY_REUSE != 0) && r_key_same && r_key_valid;
  assign w_ctr_load = (r_state == S_INIT_ADD);
  assign w_ctr_dec  = (r_state == S_ROUND) && !w_ctr_zero;

  aes_round_ctr u_round_ctr (
    .clk        (clk),
    .i_reset    (reset),
    .i_load     (w_ctr_load),
    .i_load_val (KIDX_FIRST_ROUND),
    .i_dec      (w_ctr_dec),
    .o_cnt      (w_cnt),
    .o_zero     (w_ctr_zero)
  );

  // Outputs are registered alongside the state: each branch loads the strobes of the state it enters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ctrl      <= ctrl_for(S_IDLE);
      r_key_idx   <= '0;
      r_key_valid <= 1'b0;
      r_key_same  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_key_same <= key_same;
            r_state    <= S_LOAD;
            r_ctrl     <= ctrl_for(S_LOAD);
            r_key_idx  <= '0;
          end
        end
        S_LOAD: begin
          if (w_reuse) begin
            r_state   <= S_INIT_ADD;
            r_ctrl    <= ctrl_for(S_INIT_ADD);
            r_key_idx <= KIDX_LAST;
          end else begin
            // Key store is about to be rewritten; it is not valid until expansion completes.
            r_key_valid <= 1'b0;
            r_state     <= S_KEXP;
            r_ctrl      <= ctrl_for(S_KEXP);
            r_key_idx   <= kidx_t'(1);
          end
        end
        S_KEXP: begin
          if (r_key_idx >= KIDX_LAST) begin
            r_key_valid <= 1'b1;
            r_state     <= S_INIT_ADD;
            r_ctrl      <= ctrl_for(S_INIT_ADD);
            r_key_idx   <= KIDX_LAST;
          end else begin
            r_key_idx <= r_key_idx + kidx_t'(1);
          end
        end
        S_INIT_ADD: begin
          r_state   <= S_ROUND;
          r_ctrl    <= ctrl_for(S_ROUND);
          r_key_idx <= KIDX_FIRST_ROUND;
        end
        S_ROUND: begin
          // key_idx tracks the value the round counter holds after this edge.
          if (w_cnt <= kidx_t'(1)) begin
            r_state   <= S_FINAL;
            r_ctrl    <= ctrl_for(S_FINAL);
            r_key_idx <= '0;
          end else begin
            r_key_idx <= w_cnt - kidx_t'(1);
          end
        end
        S_FINAL: begin
          r_state   <= S_DONE;
          r_ctrl    <= ctrl_for(S_DONE);
          r_key_idx <= '0;
        end
        S_DONE: begin
          if (out_ready) begin
            r_state   <= S_IDLE;
            r_ctrl    <= ctrl_for(S_IDLE);
            r_key_idx <= '0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_ctrl    <= ctrl_for(S_IDLE);
          r_key_idx <= '0;
        end
      endcase
    end
  end

  assign ready     = r_ctrl.ready;
  assign busy      = r_ctrl.busy;
  assign ct_load   = r_ctrl.ct_load;
  assign key_we    = r_ctrl.key_we;
  assign key_idx   = r_key_idx;
  assign state_en  = r_ctrl.state_en;
  assign sel_init  = r_ctrl.sel_init;
  assign sel_last  = r_ctrl.sel_last;
  assign out_valid = r_ctrl.out_valid;

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Scoreboard bench for aes_dec_ctrl: the driver queues each accepted request,
// a negedge monitor compares every cycle of the control trace against it.
module tb_aes_dec_ctrl;

  localparam int unsigned KEY_REUSE = 1;
  localparam logic [11:0] IDLE_W = 12'h800;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       start     = 1'b0;
  logic       key_same  = 1'b0;
  logic       out_ready = 1'b0;
  logic       ready, busy, ct_load, key_we, state_en, sel_init, sel_last, out_valid;
  logic [3:0] key_idx;

  int cyc     = 0;
  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    int acc;
    bit full;
    int d;
  } exp_t;

  exp_t q[$];
  bit   mkv = 1'b0;

  aes_dec_ctrl #(.KEY_REUSE(KEY_REUSE)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .key_same  (key_same),
    .ready     (ready),
    .busy      (busy),
    .ct_load   (ct_load),
    .key_we    (key_we),
    .key_idx   (key_idx),
    .state_en  (state_en),
    .sel_init  (sel_init),
    .sel_last  (sel_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: cyc=%0d did not reach end of test", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [11:0] mkw(input bit rdy, input bit bsy, input bit ctl, input bit kwe,
                                      input int idx, input bit sen, input bit si, input bit sl,
                                      input bit ov);
    return {rdy, bsy, ctl, kwe, 4'(idx), sen, si, sl, ov};
  endfunction

  // Expected outputs k cycles after acceptance: LOAD, 10 key writes (full path),
  // AddRoundKey 10, rounds 9..1, final round 0, then plaintext valid.
  function automatic logic [11:0] exp_word(input bit full, input int k);
    int nk;
    nk = full ? 10 : 0;
    if (k == 0)       return mkw(0, 1, 1, 0, 0, 0, 0, 0, 0);
    if (k <= nk)      return mkw(0, 1, 0, 1, k, 0, 0, 0, 0);
    if (k == nk + 1)  return mkw(0, 1, 0, 0, 10, 1, 1, 0, 0);
    if (k <= nk + 10) return mkw(0, 1, 0, 0, nk + 11 - k, 1, 0, 0, 0);
    if (k == nk + 11) return mkw(0, 1, 0, 0, 0, 1, 0, 1, 0);
    return mkw(0, 1, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  task automatic chk(input string nm, input int c, input logic [11:0] a, input logic [11:0] e);
    n_total++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, a, e);
    end
  endtask

  task automatic chk_int(input string nm, input int a, input int e);
    n_total++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", nm, a, e);
    end
  endtask

  logic [11:0] act;
  int          mk, mnk;
  bit          prev_ov = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      act = {ready, busy, ct_load, key_we, key_idx, state_en, sel_init, sel_last, out_valid};
      if (reset) begin
        q.delete();
        chk("reset_state", cyc, act, IDLE_W);
      end else if (q.size() == 0 || cyc < q[0].acc) begin
        chk("idle", cyc, act, IDLE_W);
      end else begin
        mk  = cyc - q[0].acc;
        mnk = q[0].full ? 10 : 0;
        chk($sformatf("op_k%0d_full%0d", mk, q[0].full), cyc, act, exp_word(q[0].full, mk));
        if (out_valid && !prev_ov)
          chk_int("latency", mk, mnk + 12);
        if (mk >= mnk + 12 + q[0].d)
          void'(q.pop_front());
      end
      prev_ov = out_valid;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run_op(input bit ks, input int hold, input int d, input bit keep);
    exp_t e;
    int   n;
    int   lat;
    start    = 1'b1;
    key_same = ks;
    e.acc    = cyc + 1;
    e.full   = !((KEY_REUSE != 0) && ks && mkv);
    e.d      = d;
    q.push_back(e);
    mkv = 1'b1;
    lat = e.full ? 22 : 12;
    n   = 0;
    step();
    while (cyc < e.acc + lat + d) begin
      if (!keep && n >= hold) start = 1'b0;
      key_same  = 1'($urandom_range(0, 1));
      out_ready = (cyc < e.acc + lat) ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      n++;
    end
    out_ready = 1'b1;
    if (!keep) start = 1'b0;
    step();
    out_ready = 1'b0;
  endtask

  task automatic run_abort(input bit ks, input int kcut);
    exp_t e;
    start     = 1'b1;
    key_same  = ks;
    out_ready = 1'b0;
    e.acc     = cyc + 1;
    e.full    = !((KEY_REUSE != 0) && ks && mkv);
    e.d       = 100;
    q.push_back(e);
    step();
    start = 1'b0;
    while (cyc < e.acc + kcut) step();
    reset     = 1'b1;
    start     = 1'b1;
    out_ready = 1'b1;
    step();
    reset     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    mkv       = 1'b0;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      key_same  = 1'($urandom_range(0, 1));
      step();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    bit ks, keep;
    int hold, d;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();

    run_op(1'b0, 0, 0, 1'b0);
    idle(2);
    run_op(1'b1, 0, 0, 1'b0);
    idle(1);

    reset = 1'b1;
    step();
    reset = 1'b0;
    mkv   = 1'b0;
    run_op(1'b1, 3, 0, 1'b0);
    run_op(1'b1, 0, 5, 1'b0);

    run_abort(1'b1, 6);
    run_op(1'b1, 0, 1, 1'b0);
    run_abort(1'b0, 5);
    run_op(1'b1, 2, 0, 1'b0);
    run_abort(1'b1, 12);
    run_op(1'b0, 0, 0, 1'b0);

    run_op(1'b1, 0, 0, 1'b1);
    run_op(1'b1, 0, 2, 1'b1);
    run_op(1'b0, 0, 0, 1'b0);
    idle(2);

    for (int it = 0; it < 25; it++) begin
      ks   = 1'($urandom_range(0, 1));
      hold = $urandom_range(0, 25);
      d    = $urandom_range(0, 4);
      keep = ($urandom_range(0, 3) == 0);
      run_op(ks, hold, d, keep);
      if (!keep) begin
        idle($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) begin
          reset = 1'b1;
          step();
          reset = 1'b0;
          mkv   = 1'b0;
        end
      end
    end
    idle(3);

    chk_int("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
